qbus_master: RTL and testbench

//  Q-bus (MPI) initiator: turns a single-word request from a local client into a

---
 rtl/qbus_pkg.sv | 31 +++
 rtl/qbus_sync2.sv | 23 ++
 rtl/qbus_master.sv | 152 +++++++++++++++
 tb/tb_qbus_master.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qbus_pkg.sv
// Shared definitions for the Q-bus (MPI) initiator: FSM state encoding,
// the active-low strobe bundle and a few well-known octal I/O addresses.
package qbus_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ASYNC,
    S_DPH,
    S_STRB,
    S_WRPLY,
    S_HOLD,
    S_WNRPLY,
    S_REL,
    S_TERM
  } state_t;

  // Control strobes as seen on the bus (all active low).
  typedef struct packed {
    logic nsync;
    logic ndin;
    logic ndout;
    logic nwtbt;
  } strobes_t;

  localparam strobes_t STROBES_IDLE = '{nsync: 1'b1, ndin: 1'b1, ndout: 1'b1, nwtbt: 1'b1};

  localparam logic [15:0] OCT_ROLL_REG = 16'o177664;
  localparam logic [15:0] OCT_KBD      = 16'o177660;

endpackage

// File: rtl/qbus_sync2.sv
// Two-flop synchronizer for an active-low asynchronous bus input.
// Ports: clk/rst (async active-high, flops reset to 1 = inactive),
//        d = asynchronous input, q = synchronized output.
module qbus_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/qbus_master.sv
// Q-bus (MPI) initiator. Runs one DATO/DATOB/DATI cycle per accepted client
// request on the multiplexed active-low nAD bus, with nRPLY handshake and a
// reply timeout that terminates the cycle with err.
// Ports:
//   PIN_CLK, PIN_R          clock, async active-high reset
//   req/we/bsel/addr/wdata  client request (sampled in IDLE)
//   busy/done/err/rdata     client status; done is a one-clock pulse, err valid with it
//   nAD_out/nAD_oe/nAD_in   tristate bus drive (inverted) and bus sample
//   PIN_nSYNC/nDIN/nDOUT/nWTBT  bus strobes (active low)
//   PIN_nRPLY               asynchronous slave reply (active low)
module qbus_master
  import qbus_pkg::*;
#(
  parameter int unsigned TMO_CYCLES = 1024,
  parameter int unsigned TMO_W      = 11
) (
  input  logic        PIN_CLK,
  input  logic        PIN_R,
  input  logic        req,
  input  logic        we,
  input  logic        bsel,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] rdata,
  output logic [15:0] nAD_out,
  output logic        nAD_oe,
  input  logic [15:0] nAD_in,
  output logic        PIN_nSYNC,
  output logic        PIN_nDIN,
  output logic        PIN_nDOUT,
  output logic        PIN_nWTBT,
  input  logic        PIN_nRPLY
);

  state_t           state, state_nx;
  strobes_t         strb;
  logic [15:0]      addr_q, wdata_q;
  logic             we_q, bsel_q;
  logic [TMO_W-1:0] cnt;
  logic             nrply_s, rply;
  logic             drive_wr;

  qbus_sync2 u_rply_sync (
    .clk (PIN_CLK),
    .rst (PIN_R),
    .d   (PIN_nRPLY),
    .q   (nrply_s)
  );

  assign rply = ~nrply_s;

  always_ff @(posedge PIN_CLK or posedge PIN_R) begin
    if (PIN_R) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      bsel_q  <= 1'b0;
      cnt     <= '0;
      rdata   <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      if (state == S_IDLE && req) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        we_q    <= we;
        bsel_q  <= bsel;
        cnt     <= '0;
        err     <= 1'b0;
      end
      if (state == S_WRPLY && cnt != '1) cnt <= cnt + 1'b1;
      if (state == S_HOLD && !we_q) rdata <= ~nAD_in;
      if (state == S_REL) done <= 1'b1;
      if (state == S_TERM) begin
        done <= 1'b1;
        err  <= 1'b1;
      end
    end
  end

  // Outputs are decoded from state so an asynchronous reset releases every
  // strobe and the bus drive in the same instant, without waiting for a clock.
  always_comb begin
    state_nx = state;
    strb     = STROBES_IDLE;
    nAD_oe   = 1'b0;
    nAD_out  = '1;
    drive_wr = 1'b0;
    case (state)
      S_IDLE: if (req) state_nx = S_ADDR;
      S_ADDR: begin
        nAD_oe     = 1'b1;
        nAD_out    = ~addr_q;
        strb.nwtbt = ~we_q;
        state_nx   = S_ASYNC;
      end
      S_ASYNC: begin
        nAD_oe     = 1'b1;
        nAD_out    = ~addr_q;
        strb.nwtbt = ~we_q;
        strb.nsync = 1'b0;
        state_nx   = S_DPH;
      end
      S_DPH, S_STRB, S_WRPLY, S_HOLD: begin
        strb.nsync = 1'b0;
        if (we_q) begin
          drive_wr   = 1'b1;
          strb.ndout = (state == S_DPH);
        end else begin
          strb.ndin  = 1'b0;
        end
        case (state)
          S_DPH:   state_nx = we_q ? S_STRB : S_WRPLY;
          S_STRB:  state_nx = S_WRPLY;
          S_WRPLY: begin
            if (rply) state_nx = S_HOLD;
            else if (cnt == TMO_W'(TMO_CYCLES - 1)) state_nx = S_TERM;
          end
          default: state_nx = S_WNRPLY;
        endcase
      end
      S_WNRPLY: begin
        drive_wr = we_q;
        if (!rply) state_nx = S_REL;
      end
      S_REL: begin
        drive_wr = we_q;
        state_nx = S_IDLE;
      end
      S_TERM:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (drive_wr) begin
      nAD_oe     = 1'b1;
      nAD_out    = ~wdata_q;
      strb.nwtbt = ~bsel_q;
    end
  end

  assign busy      = (state != S_IDLE);
  assign PIN_nSYNC = strb.nsync;
  assign PIN_nDIN  = strb.ndin;
  assign PIN_nDOUT = strb.ndout;
  assign PIN_nWTBT = strb.nwtbt;

endmodule

// File: tb/tb_qbus_master.sv
// Bench for qbus_master: behavioural Q-bus responder on the bus side, and a
// word-addressed reference memory updated from client requests.
module tb_qbus_master;

  localparam int unsigned TMO = 32;

  logic        PIN_CLK, PIN_R;
  logic        req, we, bsel;
  logic [15:0] addr, wdata;
  logic        busy, done, err;
  logic [15:0] rdata, nAD_out, nAD_in;
  logic        nAD_oe;
  logic        nSYNC, nDIN, nDOUT, nWTBT, nRPLY;

  logic        resp_oe;
  logic [15:0] resp_drv;
  logic        resp_en;
  int unsigned resp_delay;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] resp_mem [logic [15:0]];
  logic [15:0] ref_mem  [logic [15:0]];
  logic [15:0] exp_rdata;

  qbus_master #(.TMO_CYCLES(TMO), .TMO_W(6)) dut (
    .PIN_CLK  (PIN_CLK),
    .PIN_R    (PIN_R),
    .req      (req),
    .we       (we),
    .bsel     (bsel),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .rdata    (rdata),
    .nAD_out  (nAD_out),
    .nAD_oe   (nAD_oe),
    .nAD_in   (nAD_in),
    .PIN_nSYNC(nSYNC),
    .PIN_nDIN (nDIN),
    .PIN_nDOUT(nDOUT),
    .PIN_nWTBT(nWTBT),
    .PIN_nRPLY(nRPLY)
  );

  // Open-drain style bus: either party pulls lines low.
  assign nAD_in = (nAD_oe ? nAD_out : 16'hFFFF) & (resp_oe ? resp_drv : 16'hFFFF);

  initial PIN_CLK = 1'b0;
  always #5 PIN_CLK = ~PIN_CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] mem_rd(input logic [15:0] m [logic [15:0]], input logic [15:0] a);
    logic [15:0] w;
    w = a & 16'hFFFE;
    return m.exists(w) ? m[w] : 16'h0000;
  endfunction

  // Byte lane rule: odd address takes the high byte, even the low byte.
  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] a,
                                        input logic [15:0] d, input logic byte_wr);
    if (!byte_wr) return d;
    if (a[0]) return {d[15:8], old[7:0]};
    return {old[15:8], d[7:0]};
  endfunction

  // Master must never drive the bus while the slave may be driving it.
  always @(negedge PIN_CLK) if (!nDIN) chk("oe_while_ndin", {31'd0, nAD_oe}, 32'd0);

  // Behavioural responder: latch address on nSYNC fall, reply after resp_delay clocks.
  initial begin
    logic        prev_nsync, replied;
    logic [15:0] raddr;
    int unsigned rcnt;
    nRPLY = 1'b1; resp_oe = 1'b0; resp_drv = 16'hFFFF;
    prev_nsync = 1'b1; replied = 1'b0; rcnt = 0; raddr = '0;
    forever begin
      @(posedge PIN_CLK);
      #1;
      if (PIN_R) begin
        nRPLY = 1'b1; resp_oe = 1'b0; replied = 1'b0; rcnt = 0; prev_nsync = 1'b1;
        continue;
      end
      if (prev_nsync && !nSYNC) raddr = ~nAD_in;
      prev_nsync = nSYNC;
      if (!replied && (!nDIN || !nDOUT) && resp_en) begin
        rcnt++;
        if (rcnt >= resp_delay) begin
          if (!nDIN) begin
            resp_drv = ~mem_rd(resp_mem, raddr);
            resp_oe  = 1'b1;
          end else begin
            resp_mem[raddr & 16'hFFFE] = merge(mem_rd(resp_mem, raddr), raddr, ~nAD_in, !nWTBT);
          end
          nRPLY = 1'b0; replied = 1'b1;
        end
      end else if (nDIN && nDOUT) begin
        nRPLY = 1'b1; resp_oe = 1'b0; replied = 1'b0; rcnt = 0;
      end
    end
  end

  // Per-cycle observations collected by do_cycle.
  logic        got_done, got_err, saw_dout, saw_din, oe_at_din, rply_low, rel_seen, nsync_at_rel;
  logic        nwtbt_addr, nwtbt_data, first_busy;
  logic [15:0] addr_ad, dout_ad;
  logic [4:0]  pins_at_done;
  int unsigned ndin_low;

  task automatic do_cycle(input logic w, input logic b, input logic [15:0] a, input logic [15:0] d);
    req = 1'b1; we = w; bsel = b; addr = a; wdata = d;
    got_done = 0; got_err = 0; saw_dout = 0; saw_din = 0; oe_at_din = 0; rply_low = 0;
    rel_seen = 0; nsync_at_rel = 0; nwtbt_addr = 1; nwtbt_data = 1; first_busy = 1;
    addr_ad = '0; dout_ad = '0; pins_at_done = '0; ndin_low = 0;
    for (int i = 0; i < 200 && !got_done; i++) begin
      @(negedge PIN_CLK);
      req = 1'b0;
      if (busy && first_busy) begin first_busy = 0; nwtbt_addr = nWTBT; addr_ad = nAD_out; end
      if (!nDOUT && !saw_dout) begin saw_dout = 1; dout_ad = nAD_out; nwtbt_data = nWTBT; end
      if (!nDIN) begin
        if (!saw_din) begin saw_din = 1; oe_at_din = nAD_oe; nwtbt_data = nWTBT; end
        ndin_low++;
      end
      if (!nRPLY) rply_low = 1;
      else if (rply_low && !rel_seen) begin rel_seen = 1; nsync_at_rel = nSYNC; end
      if (done) begin
        got_done = 1; got_err = err;
        pins_at_done = {nSYNC, nDIN, nDOUT, nWTBT, nAD_oe};
      end
    end
    chk("done_seen", {31'd0, got_done}, 32'd1);
    if (w) ref_mem[a & 16'hFFFE] = merge(mem_rd(ref_mem, a), a, d, b);
  endtask

  initial begin
    resp_en = 1'b1; resp_delay = 3;
    req = 0; we = 0; bsel = 0; addr = '0; wdata = '0;
    PIN_R = 1'b1;
    repeat (2) @(negedge PIN_CLK);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    chk("rst_rdata", {16'd0, rdata}, 32'd0);
    chk("rst_bus", {15'd0, nAD_oe, nAD_out}, 32'h0000FFFF);
    chk("rst_strobes", {28'd0, nSYNC, nDIN, nDOUT, nWTBT}, 32'hF);
    PIN_R = 1'b0;
    exp_rdata = '0;
    @(negedge PIN_CLK);

    // 1: word write to the roll register
    do_cycle(1'b1, 1'b0, 16'o177664, 16'o001330);
    chk("w_addr_phase", {16'd0, addr_ad}, {16'd0, ~16'o177664});
    chk("w_data_phase", {16'd0, dout_ad}, {16'd0, ~16'o001330});
    chk("w_ndout", {31'd0, saw_dout}, 32'd1);
    chk("w_err", {31'd0, got_err}, 32'd0);
    chk("w_resp_reg", {16'd0, mem_rd(resp_mem, 16'o177664)}, {16'd0, 16'o001330});
    chk("w_pins_done", {27'd0, pins_at_done}, 32'b11110);

    // 2: read returning 012345
    resp_mem[16'o000016] = 16'o012345; ref_mem[16'o000016] = 16'o012345;
    do_cycle(1'b0, 1'b0, 16'o000016, 16'h0000);
    chk("r_oe_at_ndin", {31'd0, oe_at_din}, 32'd0);
    chk("r_rdata", {16'd0, rdata}, {16'd0, 16'o012345});
    chk("r_nsync_before_rply", {30'd0, rel_seen, nsync_at_rel}, 32'd3);
    chk("r_nwtbt", {31'd0, nwtbt_data}, 32'd1);
    exp_rdata = 16'o012345;

    // 3: byte write to an odd address only touches the high byte
    do_cycle(1'b1, 1'b0, 16'o000000, 16'h1234);
    do_cycle(1'b1, 1'b1, 16'o000001, 16'h00A5);
    chk("b_nwtbt_addr", {31'd0, nwtbt_addr}, 32'd0);
    chk("b_nwtbt_data", {31'd0, nwtbt_data}, 32'd0);
    chk("b_resp_reg", {16'd0, mem_rd(resp_mem, 16'o000000)}, 32'h00000034);
    chk("b_rdata_held", {16'd0, rdata}, {16'd0, exp_rdata});

    // 4: no responder -> timeout; nDIN low in DPH plus TMO clocks of waiting
    resp_en = 1'b0;
    do_cycle(1'b0, 1'b0, 16'o177660, 16'h0000);
    chk("t_err", {31'd0, got_err}, 32'd1);
    chk("t_ndin_clocks", ndin_low, TMO + 1);
    chk("t_pins_done", {27'd0, pins_at_done}, 32'b11110);
    chk("t_rdata_held", {16'd0, rdata}, {16'd0, exp_rdata});

    // 5: reset while waiting for reply
    req = 1'b1; we = 1'b1; bsel = 1'b0; addr = 16'o000100; wdata = 16'hBEEF;
    @(negedge PIN_CLK); req = 1'b0;
    repeat (10) @(negedge PIN_CLK);
    chk("x_in_wrply", {30'd0, nSYNC, nDOUT}, 32'd0);
    #2 PIN_R = 1'b1;
    #1;
    chk("x_strobes", {27'd0, nSYNC, nDIN, nDOUT, nWTBT, nAD_oe}, 32'b11110);
    chk("x_busy", {31'd0, busy}, 32'd0);
    @(negedge PIN_CLK); PIN_R = 1'b0;
    begin
      logic any_done;
      any_done = 0;
      repeat (5) begin @(negedge PIN_CLK); any_done |= done; end
      chk("x_no_done", {31'd0, any_done}, 32'd0);
    end
    chk("x_rdata_rst", {16'd0, rdata}, 32'd0);
    exp_rdata = '0;
    resp_en = 1'b1;

    // 6: req held high -> three back-to-back reads
    begin
      int unsigned ndone;
      logic chk_next;
      ndone = 0; chk_next = 0;
      req = 1'b1; we = 1'b0; bsel = 1'b0; addr = 16'o000016;
      for (int i = 0; i < 300 && ndone < 3; i++) begin
        @(negedge PIN_CLK);
        if (chk_next) begin chk("bb_restart", {31'd0, busy}, 32'd1); chk_next = 0; end
        if (done) begin
          ndone++;
          chk("bb_idle_gap", {29'd0, busy, nSYNC, nAD_oe}, 32'b010);
          chk("bb_rdata", {16'd0, rdata}, {16'd0, mem_rd(ref_mem, 16'o000016)});
          if (ndone < 3) chk_next = 1;
          else req = 1'b0;
        end
      end
      chk("bb_count", ndone, 32'd3);
      @(negedge PIN_CLK);
      chk("bb_stop", {31'd0, busy}, 32'd0);
      exp_rdata = mem_rd(ref_mem, 16'o000016);
    end

    // Random traffic against the reference memory
    for (int n = 0; n < 40; n++) begin
      logic        rw, rb;
      logic [15:0] ra, rd;
      rw = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      ra = 16'(16'o001000 + $urandom_range(0, 15));
      rd = 16'($urandom);
      resp_delay = $urandom_range(1, 5);
      do_cycle(rw, rb, ra, rd);
      chk("rnd_err", {31'd0, got_err}, 32'd0);
      if (rw) begin
        chk("rnd_wmem", {16'd0, mem_rd(resp_mem, ra)}, {16'd0, mem_rd(ref_mem, ra)});
        chk("rnd_rdata_held", {16'd0, rdata}, {16'd0, exp_rdata});
      end else begin
        exp_rdata = mem_rd(ref_mem, ra);
        chk("rnd_rdata", {16'd0, rdata}, {16'd0, exp_rdata});
      end
      @(negedge PIN_CLK);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
